ps2_keyboard_rx: RTL and testbench
==================================

// Module: ps2_keyboard_rx
// PURPOSE
//  PS/2 keyboard front end feeding the Y86 shell's keyboard port (KB_status/KB_data/KB_read_en/KB_clear).
//  Receives 11-bit PS/2 frames, checks them, translates make codes to 7-bit ASCII and queues characters.
//  The CPU polls KB_status and pops characters with KB_read_en.
// PARAMETERS
//  FILTER_LEN      8       consecutive equal mclk samples before filtered ps2_clk changes level
//  TIMEOUT_CYCLES  160000  mclk cycles (2 ms at 80 MHz) with no ps2_clk fall before a partial frame is aborted
//  FIFO_DEPTH      4       character queue entries; must be a power of 2, >= 2
// PORTS
//  mclk        in   1  system clock (80 MHz); all logic on rising edge
//  reset       in   1  synchronous, active-low reset (0 = reset)
//  ps2_clk     in   1  raw PS/2 clock, asynchronous, idles high
//  ps2_in      in   1  raw PS/2 data, asynchronous, idles high
//  KB_read_en  in   1  1-cycle pop request for the head character
//  KB_clear    in   1  flush the character queue
//  KB_status   out  1  1 = queue non-empty
//  KB_data     out  7  ASCII of oldest queued character (show-ahead); 0 when empty
//  frame_err   out  1  1-cycle pulse per aborted or rejected frame
// BEHAVIOUR
//  Reset: KB_status=0, KB_data=0, frame_err=0. Queue empty, FSM IDLE, shift/break flags clear,
//   synchronizer and filter regs = 1. A reset mid-frame discards the partial frame.
//  Input: ps2_clk and ps2_in each pass a 2-FF synchronizer. Filtered clk changes only after FILTER_LEN equal samples.
//   ps2_in is sampled on the cycle the filtered clk falls ("fall").
//  FSM: IDLE -> DATA -> PARITY -> STOP.
//   IDLE: fall with data 0 -> DATA, bit_cnt=0. Fall with data 1 -> stay in IDLE, no error.
//   DATA: shift bit in LSB first. The 8th fall -> PARITY.
//   PARITY: latch bit; 8 data bits + parity must hold an odd count of 1s.
//   STOP: fall with data 1 and parity good -> frame_valid (1 cycle) and IDLE.
//    Otherwise frame_err pulse, byte discarded, IDLE.
//  Timeout: counter clears on every fall and counts only outside IDLE.
//   At TIMEOUT_CYCLES: frame_err pulse, IDLE.
//  Decode (on frame_valid):
//   0xF0 -> set break. The next byte clears break and is otherwise ignored, except 0x12/0x59, which clear shift.
//   0xE0 -> set ext. The next byte is dropped and clears ext (extended keys unsupported).
//   0x12/0x59 make -> set shift.
//   Other codes -> ps2_scan_to_ascii({shift,code}); valid -> push, unmapped -> dropped.
//  Latency: push happens the cycle after frame_valid. KB_status/KB_data update the following cycle,
//   i.e. 2 mclk after the stop-bit sample cycle.
//  Queue (circular buffer, DEPTH+1-state count):
//   Push when full -> char dropped, contents unchanged.
//   KB_read_en when empty -> ignored.
//   Push+pop same cycle: both take effect (full stays full). When empty, only the push takes effect.
//   KB_clear -> empty next cycle; overrides same-cycle push and pop. Decoder flags unaffected.
//   Pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//  Shared package/include ps2_pkg: FSM state encodings; scan constants
//   SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59.
//  Sub-module ps2_scan_to_ascii: combinational ROM, in {shift,code[7:0]}, out {valid,ascii[6:0]}.
//   Covers letters, digits, space (0x29), enter (0x5A -> 0x0D), backspace (0x66 -> 0x08).
//   Shift selects uppercase letters and shifted digit symbols.
//  Top contains: synchronizers, filter, frame FSM, timeout counter, decode flags, queue.
// TESTING (PS/2 half-period 250 us, data changed while ps2_clk high)
//  1 Frame 0x33, parity 1, stop 1, preceded by a 3-cycle ps2_clk glitch.
//    -> glitch ignored; KB_status=1, KB_data=7'h68 ('h') 2 cycles after stop sample; frame_err stays 0.
//  2 Frames 33, F0, 33, then KB_read_en pulse -> exactly one 'h' queued; after pop KB_status=0, KB_data=0.
//  3 Frame 0x33 with parity 0 -> one frame_err pulse, KB_status stays 0.
//    Stop bit 0 -> same.
//  4 Stall 2.1 ms after 4 data bits -> frame_err pulse.
//    Next good frame 0x1C -> KB_data=7'h61 ('a').
//  5 Codes 1C,32,21,23,24 (a b c d e) with no pops -> queue holds a,b,c,d; 'e' dropped.
//    Pops return 61,62,63,64 in order.
//    Refill 1, then KB_clear coincident with a push -> KB_status=0 next cycle.
//  6 Codes 12,1C,F0,1C,F0,12,1C -> 'A'(7'h41) then 'a'(7'h61).
//    Reset asserted mid-frame -> no char, no frame_err; next frame decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared frame FSM encoding and PS/2 scan-code constants
// Purpose: types and constants shared by the PS/2 keyboard receiver files.
// Ports: none (package).
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// rtl/ps2_scan_to_ascii.sv - combinational set-2 make code to ASCII ROM
// Purpose: maps {shift, code} to {valid, ascii}; letters, digits, space, enter, backspace.
// Ports:
//   key    in  9  {shift, make code[7:0]}
//   result out 8  {valid, ascii[6:0]}; valid=0 for unmapped codes
module ps2_scan_to_ascii (
  input  logic [8:0] key,
  output logic [7:0] result
);

  // pair = {unshifted, shifted}
  logic [13:0] pair;
  logic        hit;

  always_comb begin
    pair = '0;
    hit  = 1'b1;
    case (key[7:0])
      8'h1C: pair = {7'h61, 7'h41};
      8'h32: pair = {7'h62, 7'h42};
      8'h21: pair = {7'h63, 7'h43};
      8'h23: pair = {7'h64, 7'h44};
      8'h24: pair = {7'h65, 7'h45};
      8'h2B: pair = {7'h66, 7'h46};
      8'h34: pair = {7'h67, 7'h47};
      8'h33: pair = {7'h68, 7'h48};
      8'h43: pair = {7'h69, 7'h49};
      8'h3B: pair = {7'h6A, 7'h4A};
      8'h42: pair = {7'h6B, 7'h4B};
      8'h4B: pair = {7'h6C, 7'h4C};
      8'h3A: pair = {7'h6D, 7'h4D};
      8'h31: pair = {7'h6E, 7'h4E};
      8'h44: pair = {7'h6F, 7'h4F};
      8'h4D: pair = {7'h70, 7'h50};
      8'h15: pair = {7'h71, 7'h51};
      8'h2D: pair = {7'h72, 7'h52};
      8'h1B: pair = {7'h73, 7'h53};
      8'h2C: pair = {7'h74, 7'h54};
      8'h3C: pair = {7'h75, 7'h55};
      8'h2A: pair = {7'h76, 7'h56};
      8'h1D: pair = {7'h77, 7'h57};
      8'h22: pair = {7'h78, 7'h58};
      8'h35: pair = {7'h79, 7'h59};
      8'h1A: pair = {7'h7A, 7'h5A};
      8'h16: pair = {7'h31, 7'h21};
      8'h1E: pair = {7'h32, 7'h40};
      8'h26: pair = {7'h33, 7'h23};
      8'h25: pair = {7'h34, 7'h24};
      8'h2E: pair = {7'h35, 7'h25};
      8'h36: pair = {7'h36, 7'h5E};
      8'h3D: pair = {7'h37, 7'h26};
      8'h3E: pair = {7'h38, 7'h2A};
      8'h46: pair = {7'h39, 7'h28};
      8'h45: pair = {7'h30, 7'h29};
      8'h29: pair = {7'h20, 7'h20};
      8'h5A: pair = {7'h0D, 7'h0D};
      8'h66: pair = {7'h08, 7'h08};
      default: hit = 1'b0;
    endcase
  end

  assign result = {hit, key[8] ? pair[6:0] : pair[13:7]};

endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver with ASCII character queue
// Purpose: synchronizes and filters PS/2 clock/data, receives 11-bit frames, decodes
//   make/break/shift sequences to ASCII and queues characters for CPU polling.
// Ports:
//   mclk        in   1  system clock, rising edge
//   reset       in   1  synchronous active-low reset
//   ps2_clk     in   1  raw PS/2 clock (async, idles high)
//   ps2_in      in   1  raw PS/2 data (async, idles high)
//   KB_read_en  in   1  pop head character
//   KB_clear    in   1  flush character queue
//   KB_status   out  1  queue non-empty
//   KB_data     out  7  head character, 0 when empty
//   frame_err   out  1  one-cycle pulse per aborted or rejected frame
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 160000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_in,
  input  logic       KB_read_en,
  input  logic       KB_clear,
  output logic       KB_status,
  output logic [6:0] KB_data,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ---------------- synchronizers ----------------
  logic clk_s1, clk_s2, dat_s1, dat_s2;

  always_ff @(posedge mclk) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_in;
      dat_s2 <= dat_s1;
    end
  end

  // ---------------- clock filter ----------------
  // filt_cnt counts consecutive samples that disagree with the filtered level;
  // the level flips on the FILTER_LEN-th one.
  logic          clk_filt, clk_filt_prev, fall;
  logic [FW-1:0] filt_cnt;

  always_ff @(posedge mclk) begin
    if (!reset) begin
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      filt_cnt      <= '0;
    end else begin
      clk_filt_prev <= clk_filt;
      if (clk_s2 == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall = clk_filt_prev & ~clk_filt;

  // ---------------- frame FSM ----------------
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit, parity_ok;
  logic          frame_valid, err_d, timeout;
  logic [TW-1:0] to_cnt;

  assign parity_ok = ^{shreg, parity_bit};
  assign timeout   = (state_q != ST_IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge mclk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    frame_valid = 1'b0;
    err_d       = 1'b0;
    if (timeout) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        ST_IDLE:   if (!dat_s2) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP: begin
          state_d = ST_IDLE;
          if (dat_s2 && parity_ok) frame_valid = 1'b1;
          else                     err_d       = 1'b1;
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (!reset) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= err_d;
      if (fall && !timeout) begin
        case (state_q)
          ST_IDLE: bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {dat_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: parity_bit <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  // Only runs while a frame is in progress; any fall restarts the window.
  always_ff @(posedge mclk) begin
    if (!reset || fall || timeout || state_q == ST_IDLE) to_cnt <= '0;
    else                                                  to_cnt <= to_cnt + TW'(1);
  end

  // ---------------- decode ----------------
  logic       brk_q, ext_q, shift_q, push_q;
  logic [6:0] push_char_q;
  logic [7:0] rom_out;
  logic       is_shift;

  ps2_scan_to_ascii u_rom (
    .key    ({shift_q, shreg}),
    .result (rom_out)
  );

  assign is_shift = (shreg == SC_LSHIFT) || (shreg == SC_RSHIFT);

  always_ff @(posedge mclk) begin
    if (!reset) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shift_q     <= 1'b0;
      push_q      <= 1'b0;
      push_char_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (frame_valid) begin
        // an extended prefix swallows the following byte whatever it is
        if (ext_q) begin
          ext_q <= 1'b0;
        end else if (brk_q) begin
          brk_q <= 1'b0;
          if (is_shift) shift_q <= 1'b0;
        end else if (shreg == SC_BREAK) begin
          brk_q <= 1'b1;
        end else if (shreg == SC_EXT) begin
          ext_q <= 1'b1;
        end else if (is_shift) begin
          shift_q <= 1'b1;
        end else if (rom_out[7]) begin
          push_q      <= 1'b1;
          push_char_q <= rom_out[6:0];
        end
      end
    end
  end

  // ---------------- character queue ----------------
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign do_pop  = KB_read_en && (count != '0);
  // a pop in the same cycle frees the slot, so a full queue still accepts the push
  assign do_push = push_q && ((count != CW'(FIFO_DEPTH)) || do_pop);

  always_ff @(posedge mclk) begin
    if (!reset || KB_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge mclk) begin
    if (reset && !KB_clear && do_push) mem[wr_ptr] <= push_char_q;
  end

  assign KB_status = (count != '0);
  assign KB_data   = KB_status ? mem[rd_ptr] : 7'h00;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;

  localparam int HP = 25;
  localparam int TO = 600;

  logic       mclk = 1'b0;
  logic       reset = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_in = 1'b1;
  logic       KB_read_en = 1'b0;
  logic       KB_clear = 1'b0;
  logic       KB_status;
  logic [6:0] KB_data;
  logic       frame_err;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int err0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_c;

  ps2_keyboard_rx #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (4)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_in     (ps2_in),
    .KB_read_en (KB_read_en),
    .KB_clear   (KB_clear),
    .KB_status  (KB_status),
    .KB_data    (KB_data),
    .frame_err  (frame_err)
  );

  always #5 mclk = ~mclk;

  always @(negedge mclk) if (frame_err === 1'b1) err_cnt++;

  task automatic ps2_bit(input logic b);
    @(negedge mclk); ps2_in = b;
    repeat (HP) @(negedge mclk); ps2_clk = 1'b0;
    repeat (HP) @(negedge mclk); ps2_clk = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] code, input int nbits, input logic par);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(code[i]);
    if (nbits == 8) ps2_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    send_head(code, 8, (~^code) ^ bad_par);
    ps2_bit(~bad_stop);
    repeat (2 * HP) @(negedge mclk);
  endtask

  task automatic stop_fall();
    @(negedge mclk); ps2_in = 1'b1;
    repeat (HP) @(negedge mclk); ps2_clk = 1'b0;
  endtask

  task automatic stop_rise();
    repeat (HP) @(negedge mclk); ps2_clk = 1'b1;
    repeat (2 * HP) @(negedge mclk);
  endtask

  task automatic pulse_read();
    @(negedge mclk); KB_read_en = 1'b1;
    @(negedge mclk); KB_read_en = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge mclk); KB_clear = 1'b1;
    @(negedge mclk); KB_clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) @(negedge mclk);
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL reset_status got=%b want=0", KB_status); end
    total++; if (KB_data !== 7'h00) begin bad++; $display("FAIL reset_data got=%h want=00", KB_data); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", frame_err); end
    reset = 1'b1;
    repeat (20) @(negedge mclk);
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL post_reset_status got=%b want=0", KB_status); end
  endtask

  task automatic test_glitch_latency();
    err0 = err_cnt;
    @(negedge mclk); ps2_in = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(negedge mclk); ps2_clk = 1'b1; ps2_in = 1'b1;
    repeat (2 * HP) @(negedge mclk);
    send_head(8'h33, 8, 1'b1);
    exp_q.push_back(7'h68);
    stop_fall();
    repeat (11) @(negedge mclk);
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL lat_early got=%b want=0", KB_status); end
    @(negedge mclk);
    total++; if (KB_status !== 1'b1) begin bad++; $display("FAIL lat_status got=%b want=1", KB_status); end
    total++; if (KB_data !== exp_q[0]) begin bad++; $display("FAIL lat_data got=%h want=%h", KB_data, exp_q[0]); end
    stop_rise();
    total++; if (err_cnt !== err0) begin bad++; $display("FAIL glitch_err got=%0d want=%0d", err_cnt, err0); end
    pulse_clear();
  endtask

  task automatic test_break();
    send_frame(8'h33, 1'b0, 1'b0); exp_q.push_back(7'h68);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    total++; if (KB_status !== 1'b1) begin bad++; $display("FAIL brk_status got=%b want=1", KB_status); end
    exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
    total++; if (KB_data !== exp_c) begin bad++; $display("FAIL brk_data got=%h want=%h", KB_data, exp_c); end
    pulse_read();
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL brk_pop_status got=%b want=0", KB_status); end
    total++; if (KB_data !== 7'h00) begin bad++; $display("FAIL brk_pop_data got=%h want=00", KB_data); end
    pulse_read();
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL empty_pop got=%b want=0", KB_status); end
  endtask

  task automatic test_bad_frames();
    err0 = err_cnt;
    send_frame(8'h33, 1'b1, 1'b0);
    total++; if (err_cnt !== err0 + 1) begin bad++; $display("FAIL parity_err got=%0d want=%0d", err_cnt, err0 + 1); end
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL parity_status got=%b want=0", KB_status); end
    send_frame(8'h33, 1'b0, 1'b1);
    total++; if (err_cnt !== err0 + 2) begin bad++; $display("FAIL stop_err got=%0d want=%0d", err_cnt, err0 + 2); end
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL stop_status got=%b want=0", KB_status); end
  endtask

  task automatic test_timeout();
    err0 = err_cnt;
    send_head(8'h1C, 4, 1'b0);
    repeat (TO + TO / 20 + 30) @(negedge mclk);
    total++; if (err_cnt !== err0 + 1) begin bad++; $display("FAIL timeout_err got=%0d want=%0d", err_cnt, err0 + 1); end
    send_frame(8'h1C, 1'b0, 1'b0); exp_q.push_back(7'h61);
    exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
    total++; if (KB_data !== exp_c) begin bad++; $display("FAIL timeout_next got=%h want=%h", KB_data, exp_c); end
    total++; if (err_cnt !== err0 + 1) begin bad++; $display("FAIL timeout_extra got=%0d want=%0d", err_cnt, err0 + 1); end
    pulse_clear();
  endtask

  task automatic test_queue();
    logic [7:0] codes [5];
    logic [6:0] chars [5];
    codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    chars = '{7'h61, 7'h62, 7'h63, 7'h64, 7'h65};
    for (int i = 0; i < 5; i++) begin
      send_frame(codes[i], 1'b0, 1'b0);
      if (exp_q.size() < 4) exp_q.push_back(chars[i]);
    end
    for (int i = 0; i < 4; i++) begin
      exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
      total++; if (KB_data !== exp_c) begin bad++; $display("FAIL fifo_pop%0d got=%h want=%h", i, KB_data, exp_c); end
      pulse_read();
    end
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL fifo_drained got=%b want=0", KB_status); end
    send_frame(8'h1C, 1'b0, 1'b0);
    total++; if (KB_data !== 7'h61) begin bad++; $display("FAIL refill got=%h want=61", KB_data); end
    send_head(8'h32, 8, ~^8'h32);
    stop_fall();
    repeat (11) @(negedge mclk);
    KB_clear = 1'b1;
    @(negedge mclk); KB_clear = 1'b0;
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL clear_push got=%b want=0", KB_status); end
    stop_rise();
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL clear_hold got=%b want=0", KB_status); end
    exp_q.delete();
  endtask

  task automatic test_shift_and_reset();
    logic [7:0] codes [7];
    codes = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    for (int i = 0; i < 7; i++) send_frame(codes[i], 1'b0, 1'b0);
    exp_q.push_back(7'h41);
    exp_q.push_back(7'h61);
    for (int i = 0; i < 2; i++) begin
      exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
      total++; if (KB_data !== exp_c) begin bad++; $display("FAIL shift%0d got=%h want=%h", i, KB_data, exp_c); end
      pulse_read();
    end
    err0 = err_cnt;
    send_head(8'h1C, 4, 1'b0);
    @(negedge mclk); reset = 1'b0;
    repeat (4) @(negedge mclk);
    ps2_clk = 1'b1; ps2_in = 1'b1; reset = 1'b1;
    repeat (2 * TO) @(negedge mclk);
    total++; if (err_cnt !== err0) begin bad++; $display("FAIL midreset_err got=%0d want=%0d", err_cnt, err0); end
    total++; if (KB_status !== 1'b0) begin bad++; $display("FAIL midreset_status got=%b want=0", KB_status); end
    send_frame(8'h24, 1'b0, 1'b0); exp_q.push_back(7'h65);
    exp_c = (exp_q.size() != 0) ? exp_q.pop_front() : 7'h7F;
    total++; if (KB_data !== exp_c) begin bad++; $display("FAIL after_reset got=%h want=%h", KB_data, exp_c); end
  endtask

  initial begin
    test_reset();
    test_glitch_latency();
    test_break();
    test_bad_frames();
    test_timeout();
    test_queue();
    test_shift_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
